// File: rtl/bfly_k.sv
// bfly_k: three-stage Kyber NTT butterfly (q = 3329), CT or GS per triple, with internal Barrett reducer red_k.
// Optional macro BFLY_K_SCALE_EN: GS outputs are multiplied by 2^-1 mod q in S3.

module red_k (
    input  logic [23:0] p,
    output logic [11:0] t
);
    localparam int unsigned Q = 3329;
    // floor(2^24 / q); for p < q^2 the quotient estimate is low by at most one
    localparam int unsigned M = 5039;

    logic [12:0] qe;
    logic [12:0] r;

    always_comb begin
        qe = 13'(({13'd0, p} * 37'(M)) >> 24);
        r  = 13'({1'b0, p} - 25'(qe) * 25'(Q));
        t  = (r >= 13'(Q)) ? 12'(r - 13'(Q)) : r[11:0];
    end
endmodule

module bfly_k #(
    parameter int Q = 3329,
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] zeta_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);
    localparam logic [W:0] QE = Q[W:0];

    function automatic logic [W-1:0] add_q(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= QE) ? W'(s - QE) : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_q(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[W] ? W'(d + QE) : d[W-1:0];
    endfunction

`ifdef BFLY_K_SCALE_EN
    function automatic logic [W-1:0] half_q(input logic [W-1:0] x);
        logic [W:0] e;
        e = x[0] ? ({1'b0, x} + QE) : {1'b0, x};
        return e[W:1];
    endfunction
`endif

    logic           v1, v2, v3;
    logic           m1, m2;
    logic [W-1:0]   x1, x2, t2;
    logic [2*W-1:0] p1;
    logic           en1, en2, en3;
    logic [W-1:0]   x_in, y_in, t_red, na, nb;
    logic [2*W-1:0] p_in;

    always_comb begin
        en3     = !v3 || ready_i;
        en2     = !v2 || en3;
        en1     = !v1 || en2;
        ready_o = en1;
        valid_o = v3;
    end

    // S1: CT forwards a and multiplies b; GS forwards a+b and multiplies a-b
    always_comb begin
        if (mode_i) begin
            x_in = add_q(a_i, b_i);
            y_in = sub_q(a_i, b_i);
        end else begin
            x_in = a_i;
            y_in = b_i;
        end
        p_in = {{W{1'b0}}, y_in} * {{W{1'b0}}, zeta_i};
    end

    red_k u_red (
        .p (p1),
        .t (t_red)
    );

    always_comb begin
        if (m2) begin
`ifdef BFLY_K_SCALE_EN
            na = half_q(x2);
            nb = half_q(t2);
`else
            na = x2;
            nb = t2;
`endif
        end else begin
            na = add_q(x2, t2);
            nb = sub_q(x2, t2);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            m1  <= 1'b0;
            m2  <= 1'b0;
            x1  <= '0;
            p1  <= '0;
            x2  <= '0;
            t2  <= '0;
            a_o <= '0;
            b_o <= '0;
        end else begin
            if (en1) begin
                v1 <= valid_i;
                if (valid_i) begin
                    m1 <= mode_i;
                    x1 <= x_in;
                    p1 <= p_in;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    m2 <= m1;
                    x2 <= x1;
                    t2 <= t_red;
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) begin
                    a_o <= na;
                    b_o <= nb;
                end
            end
        end
    end
endmodule
